// File: rtl/minisys_id_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : minisys_id_stage_pkg
// Brief   : Opcodes, function codes, ALU/MD codes and ID/EX bundle types.
// Revision: 1.0
// ============================================================================
package minisys_id_stage_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU = 6'h0B;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LB    = 6'h20;
    localparam logic [5:0] c_OP_LH    = 6'h21;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_LBU   = 6'h24;
    localparam logic [5:0] c_OP_LHU   = 6'h25;
    localparam logic [5:0] c_OP_SB    = 6'h28;
    localparam logic [5:0] c_OP_SH    = 6'h29;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_SLL   = 6'h00;
    localparam logic [5:0] c_FN_SRL   = 6'h02;
    localparam logic [5:0] c_FN_SRA   = 6'h03;
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [5:0] c_FN_JALR  = 6'h09;
    localparam logic [5:0] c_FN_MFHI  = 6'h10;
    localparam logic [5:0] c_FN_MFLO  = 6'h12;
    localparam logic [5:0] c_FN_MULT  = 6'h18;
    localparam logic [5:0] c_FN_MULTU = 6'h19;
    localparam logic [5:0] c_FN_DIV   = 6'h1A;
    localparam logic [5:0] c_FN_DIVU  = 6'h1B;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_ADDU  = 6'h21;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_SUBU  = 6'h23;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_XOR   = 6'h26;
    localparam logic [5:0] c_FN_NOR   = 6'h27;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;
    localparam logic [5:0] c_FN_SLTU  = 6'h2B;

    localparam logic [3:0] c_ALU_ADD  = 4'h0;
    localparam logic [3:0] c_ALU_SUB  = 4'h1;
    localparam logic [3:0] c_ALU_AND  = 4'h2;
    localparam logic [3:0] c_ALU_OR   = 4'h3;
    localparam logic [3:0] c_ALU_XOR  = 4'h4;
    localparam logic [3:0] c_ALU_NOR  = 4'h5;
    localparam logic [3:0] c_ALU_SLT  = 4'h6;
    localparam logic [3:0] c_ALU_SLTU = 4'h7;
    localparam logic [3:0] c_ALU_SLL  = 4'h8;
    localparam logic [3:0] c_ALU_SRL  = 4'h9;
    localparam logic [3:0] c_ALU_SRA  = 4'hA;
    localparam logic [3:0] c_ALU_LUI  = 4'hB;
    localparam logic [3:0] c_ALU_ADDU = 4'hC;
    localparam logic [3:0] c_ALU_SUBU = 4'hD;

    localparam logic [1:0] c_MD_MULT  = 2'b00;
    localparam logic [1:0] c_MD_MULTU = 2'b01;
    localparam logic [1:0] c_MD_DIV   = 2'b10;
    localparam logic [1:0] c_MD_DIVU  = 2'b11;

    localparam logic [4:0] c_ZERO_REG = 5'd0;
    localparam logic [4:0] c_LINK_REG = 5'd31;

    typedef struct packed {
        logic       regwrite;
        logic       mem2reg;
        logic       branch;
        logic       alusrc;
        logic [3:0] alucontrol;
        logic [3:0] memwrite;
        logic       opLb;
        logic       opLbu;
        logic       opLh;
        logic       opLhu;
        logic       opLw;
        logic       write31;
        logic       opBeq;
        logic       opBne;
        logic [1:0] aluMd;
        logic       md;
        logic       mfhi;
        logic       mflo;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  writeReg;
        logic [31:0] imm;
        logic [31:0] pcplus4;
        logic [31:0] hi;
        logic [31:0] lo;
    } idex_t;

endpackage
`default_nettype wire

// File: rtl/minisys_id_stage_regfile.sv
`default_nettype none
// ============================================================================
// Module  : minisys_regfile
// Brief   : 32x32 GPR file, $0 hardwired, reads bypass a same-cycle WB write.
// Revision: 1.0
// ============================================================================
module minisys_regfile
    import minisys_id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] r_regs [0:31];
    logic        w_wrEn;

    assign w_wrEn = we && (wa != c_ZERO_REG);

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (w_wrEn) begin
            r_regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == c_ZERO_REG) ? 32'd0 : (w_wrEn && wa == ra1) ? wd : r_regs[ra1];
    assign rd2 = (ra2 == c_ZERO_REG) ? 32'd0 : (w_wrEn && wa == ra2) ? wd : r_regs[ra2];

endmodule
`default_nettype wire

// File: rtl/minisys_id_stage.sv
`default_nettype none
// ============================================================================
// Module  : minisys_id_stage
// Brief   : Minisys-1A decode stage: regfile, HI/LO, decode, jumps, hazards, ID/EX.
// Revision: 1.0
// ============================================================================
module minisys_id_stage
    import minisys_id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] instrD,
    input  logic [31:0] pcplus4D,
    input  logic        regwriteW,
    input  logic [4:0]  write_regW,
    input  logic [31:0] result_to_writeW,
    input  logic        mdcsE2D,
    input  logic [31:0] mdhidataE2D,
    input  logic [31:0] mdlodataE2D,
    input  logic        mdcsW,
    input  logic [31:0] mdhidataW,
    input  logic [31:0] mdlodataW,
    input  logic        keepmdE,
    input  logic        multbusyE,
    input  logic        multoverE,
    input  logic        divbusyE,
    input  logic        divoverE,
    output logic        regwriteE,
    output logic        mem2regE,
    output logic        branchE,
    output logic        alusrcE,
    output logic [3:0]  alucontrolE,
    output logic [3:0]  memwriteE,
    output logic [31:0] rd1E,
    output logic [31:0] rd2E,
    output logic [4:0]  rsE,
    output logic [4:0]  rtE,
    output logic [4:0]  rdE,
    output logic [4:0]  write_regE,
    output logic [31:0] signImmeE,
    output logic [31:0] pcplus4E,
    output logic        op_lbE,
    output logic        op_lbuE,
    output logic        op_lhE,
    output logic        op_lhuE,
    output logic        op_lwE,
    output logic        write_$31E,
    output logic        op_beqE,
    output logic        op_bneE,
    output logic [1:0]  alu_mdE,
    output logic        mdE,
    output logic        mfhiE,
    output logic        mfloE,
    output logic [31:0] hi2rdataE,
    output logic [31:0] lo2rdataE,
    output logic        load_use,
    output logic        MDPause,
    output logic [31:0] pc_jumpI,
    output logic        jumpI
);
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_dest;
    logic [31:0] w_rsVal, w_rtVal, w_imm, w_hi, w_lo;
    logic        w_zeroExt, w_rsUsed, w_rtUsed, w_isMd, w_mdOp, w_jumpImm, w_jumpReg;
    ctrl_t       w_ctrl;
    idex_t       w_idexNext, r_idex;
    logic [31:0] r_hi, r_lo;

    assign w_op    = instrD[31:26];
    assign w_rs    = instrD[25:21];
    assign w_rt    = instrD[20:16];
    assign w_rd    = instrD[15:11];
    assign w_funct = instrD[5:0];

    minisys_regfile u_regfile (
        .clk  (clk),
        .clrn (clrn),
        .we   (regwriteW),
        .wa   (write_regW),
        .wd   (result_to_writeW),
        .ra1  (w_rs),
        .ra2  (w_rt),
        .rd1  (w_rsVal),
        .rd2  (w_rtVal)
    );

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (mdcsW) begin
            r_hi <= mdhidataW;
            r_lo <= mdlodataW;
        end
    end

    // EXE result is newer than WB, which is newer than the stored copy
    assign w_hi = mdcsE2D ? mdhidataE2D : mdcsW ? mdhidataW : r_hi;
    assign w_lo = mdcsE2D ? mdlodataE2D : mdcsW ? mdlodataW : r_lo;

    always_comb begin
        w_ctrl    = '0;
        w_dest    = c_ZERO_REG;
        w_zeroExt = 1'b0;
        w_rsUsed  = 1'b0;
        w_rtUsed  = 1'b0;
        w_isMd    = 1'b0;
        w_mdOp    = 1'b0;
        w_jumpImm = 1'b0;
        w_jumpReg = 1'b0;
        case (w_op)
            c_OP_RTYPE: begin
                w_dest          = w_rd;
                w_rsUsed        = 1'b1;
                w_rtUsed        = 1'b1;
                w_ctrl.regwrite = 1'b1;
                case (w_funct)
                    c_FN_ADD:   w_ctrl.alucontrol = c_ALU_ADD;
                    c_FN_ADDU:  w_ctrl.alucontrol = c_ALU_ADDU;
                    c_FN_SUB:   w_ctrl.alucontrol = c_ALU_SUB;
                    c_FN_SUBU:  w_ctrl.alucontrol = c_ALU_SUBU;
                    c_FN_AND:   w_ctrl.alucontrol = c_ALU_AND;
                    c_FN_OR:    w_ctrl.alucontrol = c_ALU_OR;
                    c_FN_XOR:   w_ctrl.alucontrol = c_ALU_XOR;
                    c_FN_NOR:   w_ctrl.alucontrol = c_ALU_NOR;
                    c_FN_SLT:   w_ctrl.alucontrol = c_ALU_SLT;
                    c_FN_SLTU:  w_ctrl.alucontrol = c_ALU_SLTU;
                    c_FN_SLL:   begin w_ctrl.alucontrol = c_ALU_SLL; w_rsUsed = 1'b0; end
                    c_FN_SRL:   begin w_ctrl.alucontrol = c_ALU_SRL; w_rsUsed = 1'b0; end
                    c_FN_SRA:   begin w_ctrl.alucontrol = c_ALU_SRA; w_rsUsed = 1'b0; end
                    c_FN_JR:    begin w_ctrl.regwrite = 1'b0; w_dest = c_ZERO_REG;
                                      w_rtUsed = 1'b0; w_jumpReg = 1'b1; end
                    c_FN_JALR:  begin w_ctrl.write31 = 1'b1; w_rtUsed = 1'b0; w_jumpReg = 1'b1; end
                    c_FN_MFHI:  begin w_ctrl.mfhi = 1'b1; w_isMd = 1'b1;
                                      w_rsUsed = 1'b0; w_rtUsed = 1'b0; end
                    c_FN_MFLO:  begin w_ctrl.mflo = 1'b1; w_isMd = 1'b1;
                                      w_rsUsed = 1'b0; w_rtUsed = 1'b0; end
                    c_FN_MULT:  begin w_ctrl.aluMd = c_MD_MULT;  w_mdOp = 1'b1; end
                    c_FN_MULTU: begin w_ctrl.aluMd = c_MD_MULTU; w_mdOp = 1'b1; end
                    c_FN_DIV:   begin w_ctrl.aluMd = c_MD_DIV;   w_mdOp = 1'b1; end
                    c_FN_DIVU:  begin w_ctrl.aluMd = c_MD_DIVU;  w_mdOp = 1'b1; end
                    default: begin
                        w_ctrl   = '0;
                        w_dest   = c_ZERO_REG;
                        w_rsUsed = 1'b0;
                        w_rtUsed = 1'b0;
                    end
                endcase
                if (w_mdOp) begin
                    w_ctrl.regwrite = 1'b0;
                    w_ctrl.md       = 1'b1;
                    w_dest          = c_ZERO_REG;
                    w_isMd          = 1'b1;
                end
            end
            c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI, c_OP_SLTIU,
            c_OP_ANDI, c_OP_ORI, c_OP_XORI, c_OP_LUI: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.alusrc   = 1'b1;
                w_dest          = w_rt;
                w_rsUsed        = (w_op != c_OP_LUI);
                w_zeroExt       = (w_op == c_OP_ANDI) || (w_op == c_OP_ORI) || (w_op == c_OP_XORI);
                case (w_op)
                    c_OP_ADDIU: w_ctrl.alucontrol = c_ALU_ADDU;
                    c_OP_SLTI:  w_ctrl.alucontrol = c_ALU_SLT;
                    c_OP_SLTIU: w_ctrl.alucontrol = c_ALU_SLTU;
                    c_OP_ANDI:  w_ctrl.alucontrol = c_ALU_AND;
                    c_OP_ORI:   w_ctrl.alucontrol = c_ALU_OR;
                    c_OP_XORI:  w_ctrl.alucontrol = c_ALU_XOR;
                    c_OP_LUI:   w_ctrl.alucontrol = c_ALU_LUI;
                    default:    w_ctrl.alucontrol = c_ALU_ADD;
                endcase
            end
            c_OP_LB, c_OP_LBU, c_OP_LH, c_OP_LHU, c_OP_LW: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.mem2reg  = 1'b1;
                w_ctrl.alusrc   = 1'b1;
                w_ctrl.opLb     = (w_op == c_OP_LB);
                w_ctrl.opLbu    = (w_op == c_OP_LBU);
                w_ctrl.opLh     = (w_op == c_OP_LH);
                w_ctrl.opLhu    = (w_op == c_OP_LHU);
                w_ctrl.opLw     = (w_op == c_OP_LW);
                w_dest          = w_rt;
                w_rsUsed        = 1'b1;
            end
            c_OP_SB, c_OP_SH, c_OP_SW: begin
                w_ctrl.alusrc   = 1'b1;
                w_ctrl.memwrite = (w_op == c_OP_SW) ? 4'b1111 : (w_op == c_OP_SH) ? 4'b0011 : 4'b0001;
                w_rsUsed        = 1'b1;
                w_rtUsed        = 1'b1;
            end
            c_OP_BEQ, c_OP_BNE: begin
                w_ctrl.branch     = 1'b1;
                w_ctrl.alucontrol = c_ALU_SUB;
                w_ctrl.opBeq      = (w_op == c_OP_BEQ);
                w_ctrl.opBne      = (w_op == c_OP_BNE);
                w_rsUsed          = 1'b1;
                w_rtUsed          = 1'b1;
            end
            c_OP_J: w_jumpImm = 1'b1;
            c_OP_JAL: begin
                w_jumpImm       = 1'b1;
                w_ctrl.regwrite = 1'b1;
                w_ctrl.write31  = 1'b1;
                w_dest          = c_LINK_REG;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign w_imm    = w_zeroExt ? {16'd0, instrD[15:0]} : {{16{instrD[15]}}, instrD[15:0]};
    assign jumpI    = w_jumpImm | w_jumpReg;
    assign pc_jumpI = w_jumpReg ? w_rsVal : {pcplus4D[31:28], instrD[25:0], 2'b00};

    assign load_use = r_idex.ctrl.mem2reg && (r_idex.writeReg != c_ZERO_REG) &&
                      ((w_rsUsed && r_idex.writeReg == w_rs) || (w_rtUsed && r_idex.writeReg == w_rt));
    assign MDPause  = w_isMd && (keepmdE || (multbusyE && !multoverE) || (divbusyE && !divoverE));

    always_comb begin
        w_idexNext = '0;
        if (!(load_use || MDPause)) begin
            w_idexNext.ctrl     = w_ctrl;
            w_idexNext.rd1      = w_rsVal;
            w_idexNext.rd2      = w_rtVal;
            w_idexNext.rs       = w_rs;
            w_idexNext.rt       = w_rt;
            w_idexNext.rd       = w_rd;
            w_idexNext.writeReg = w_dest;
            w_idexNext.imm      = w_imm;
            w_idexNext.pcplus4  = pcplus4D;
            w_idexNext.hi       = w_hi;
            w_idexNext.lo       = w_lo;
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) r_idex <= '0;
        else      r_idex <= w_idexNext;
    end

    assign regwriteE   = r_idex.ctrl.regwrite;
    assign mem2regE    = r_idex.ctrl.mem2reg;
    assign branchE     = r_idex.ctrl.branch;
    assign alusrcE     = r_idex.ctrl.alusrc;
    assign alucontrolE = r_idex.ctrl.alucontrol;
    assign memwriteE   = r_idex.ctrl.memwrite;
    assign op_lbE      = r_idex.ctrl.opLb;
    assign op_lbuE     = r_idex.ctrl.opLbu;
    assign op_lhE      = r_idex.ctrl.opLh;
    assign op_lhuE     = r_idex.ctrl.opLhu;
    assign op_lwE      = r_idex.ctrl.opLw;
    assign write_$31E  = r_idex.ctrl.write31;
    assign op_beqE     = r_idex.ctrl.opBeq;
    assign op_bneE     = r_idex.ctrl.opBne;
    assign alu_mdE     = r_idex.ctrl.aluMd;
    assign mdE         = r_idex.ctrl.md;
    assign mfhiE       = r_idex.ctrl.mfhi;
    assign mfloE       = r_idex.ctrl.mflo;
    assign rd1E        = r_idex.rd1;
    assign rd2E        = r_idex.rd2;
    assign rsE         = r_idex.rs;
    assign rtE         = r_idex.rt;
    assign rdE         = r_idex.rd;
    assign write_regE  = r_idex.writeReg;
    assign signImmeE   = r_idex.imm;
    assign pcplus4E    = r_idex.pcplus4;
    assign hi2rdataE   = r_idex.hi;
    assign lo2rdataE   = r_idex.lo;

endmodule
`default_nettype wire

// File: tb/tb_minisys_id_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_minisys_id_stage
// Brief   : Directed vectors for the ID stage with a queue-based ID/EX scoreboard.
// Revision: 1.0
// ============================================================================
module tb_minisys_id_stage;

    logic        clk, clrn;
    logic [31:0] instrD, pcplus4D;
    logic        regwriteW;
    logic [4:0]  write_regW;
    logic [31:0] result_to_writeW;
    logic        mdcsE2D, mdcsW, keepmdE, multbusyE, multoverE, divbusyE, divoverE;
    logic [31:0] mdhidataE2D, mdlodataE2D, mdhidataW, mdlodataW;
    logic        regwriteE, mem2regE, branchE, alusrcE;
    logic [3:0]  alucontrolE, memwriteE;
    logic [31:0] rd1E, rd2E, signImmeE, pcplus4E, hi2rdataE, lo2rdataE, pc_jumpI;
    logic [4:0]  rsE, rtE, rdE, write_regE;
    logic        op_lbE, op_lbuE, op_lhE, op_lhuE, op_lwE, write_$31E, op_beqE, op_bneE;
    logic [1:0]  alu_mdE;
    logic        mdE, mfhiE, mfloE, load_use, MDPause, jumpI;

    minisys_id_stage dut (
        .clk(clk), .clrn(clrn), .instrD(instrD), .pcplus4D(pcplus4D),
        .regwriteW(regwriteW), .write_regW(write_regW), .result_to_writeW(result_to_writeW),
        .mdcsE2D(mdcsE2D), .mdhidataE2D(mdhidataE2D), .mdlodataE2D(mdlodataE2D),
        .mdcsW(mdcsW), .mdhidataW(mdhidataW), .mdlodataW(mdlodataW),
        .keepmdE(keepmdE), .multbusyE(multbusyE), .multoverE(multoverE),
        .divbusyE(divbusyE), .divoverE(divoverE),
        .regwriteE(regwriteE), .mem2regE(mem2regE), .branchE(branchE), .alusrcE(alusrcE),
        .alucontrolE(alucontrolE), .memwriteE(memwriteE), .rd1E(rd1E), .rd2E(rd2E),
        .rsE(rsE), .rtE(rtE), .rdE(rdE), .write_regE(write_regE),
        .signImmeE(signImmeE), .pcplus4E(pcplus4E),
        .op_lbE(op_lbE), .op_lbuE(op_lbuE), .op_lhE(op_lhE), .op_lhuE(op_lhuE), .op_lwE(op_lwE),
        .write_$31E(write_$31E), .op_beqE(op_beqE), .op_bneE(op_bneE),
        .alu_mdE(alu_mdE), .mdE(mdE), .mfhiE(mfhiE), .mfloE(mfloE),
        .hi2rdataE(hi2rdataE), .lo2rdataE(lo2rdataE),
        .load_use(load_use), .MDPause(MDPause), .pc_jumpI(pc_jumpI), .jumpI(jumpI)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  id;
        logic        regwrite, mem2reg, branch, alusrc;
        logic [3:0]  aluc, memw;
        logic [4:0]  loads;   // {lb, lbu, lh, lhu, lw}
        logic        w31;
        logic [1:0]  br;      // {beq, bne}
        logic [1:0]  aluMd;
        logic        md, mfhi, mflo;
        logic [4:0]  wreg;
        logic [14:0] regs;    // {rs, rt, rd}
        logic [31:0] rd1, rd2, imm, pc4, hi, lo;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          nChecks = 0;
    int          nErr = 0;
    logic [31:0] mHi = 0, mLo = 0;
    logic [24:0] actCtrl;

    assign actCtrl = {regwriteE, mem2regE, branchE, alusrcE, alucontrolE, memwriteE,
                      op_lbE, op_lbuE, op_lhE, op_lhuE, op_lwE, write_$31E, op_beqE, op_bneE,
                      alu_mdE, mdE, mfhiE, mfloE};

    function automatic logic [24:0] packCtrl(input exp_t x);
        return {x.regwrite, x.mem2reg, x.branch, x.alusrc, x.aluc, x.memw, x.loads, x.w31,
                x.br, x.aluMd, x.md, x.mfhi, x.mflo};
    endfunction

    function automatic exp_t base(input logic [7:0] id, input logic [31:0] ins,
                                  input logic [31:0] pc4, input logic [31:0] rd1,
                                  input logic [31:0] rd2);
        exp_t x;
        x      = '0;
        x.id   = id;
        x.regs = ins[25:11];
        x.rd1  = rd1;
        x.rd2  = rd2;
        x.imm  = {{16{ins[15]}}, ins[15:0]};
        x.pc4  = pc4;
        x.hi   = mHi;
        x.lo   = mLo;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        regwriteW = 0; write_regW = 0; result_to_writeW = 0;
        mdcsE2D = 0; mdhidataE2D = 0; mdlodataE2D = 0;
        mdcsW = 0; mdhidataW = 0; mdlodataW = 0;
        keepmdE = 0; multbusyE = 0; multoverE = 0; divbusyE = 0; divoverE = 0;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc4, input exp_t x);
        instrD   = ins;
        pcplus4D = pc4;
        sb.push_back(x);
        #1;
    endtask

    // Monitor: whatever was issued before this edge is what ID/EX now holds
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                #1;
                chk($sformatf("s%0d ctrl", x.id), {7'd0, actCtrl}, {7'd0, packCtrl(x)});
                chk($sformatf("s%0d write_regE", x.id), {27'd0, write_regE}, {27'd0, x.wreg});
                chk($sformatf("s%0d rs/rt/rd", x.id), {17'd0, rsE, rtE, rdE}, {17'd0, x.regs});
                chk($sformatf("s%0d rd1E", x.id), rd1E, x.rd1);
                chk($sformatf("s%0d rd2E", x.id), rd2E, x.rd2);
                chk($sformatf("s%0d signImmeE", x.id), signImmeE, x.imm);
                chk($sformatf("s%0d pcplus4E", x.id), pcplus4E, x.pc4);
                chk($sformatf("s%0d hi2rdataE", x.id), hi2rdataE, x.hi);
                chk($sformatf("s%0d lo2rdataE", x.id), lo2rdataE, x.lo);
            end
        end
    end

    initial begin : stim
        clrn = 1; instrD = 0; pcplus4D = 0;
        regwriteW = 0; write_regW = 0; result_to_writeW = 0;
        mdcsE2D = 0; mdhidataE2D = 0; mdlodataE2D = 0;
        mdcsW = 0; mdhidataW = 0; mdlodataW = 0;
        keepmdE = 0; multbusyE = 0; multoverE = 0; divbusyE = 0; divoverE = 0;
        #12;
        chk("reset ctrl", {7'd0, actCtrl}, 32'd0);
        chk("reset write_regE", {27'd0, write_regE}, 32'd0);
        chk("reset pcplus4E", pcplus4E, 32'd0);
        chk("reset hi2rdataE", hi2rdataE, 32'd0);
        @(negedge clk); clrn = 0;

        // addi $1,$0,1
        cyc(); e = base(1, 32'h20010001, 32'h4, 0, 0);
        e.regwrite = 1; e.alusrc = 1; e.wreg = 1;
        drive(32'h20010001, 32'h4, e);
        chk("addi jumpI", {31'd0, jumpI}, 32'd0);
        // add $3,$6,$0 with WB writing $6=6 the same cycle
        cyc(); regwriteW = 1; write_regW = 6; result_to_writeW = 6;
        e = base(2, 32'h00C01820, 32'h8, 6, 0); e.regwrite = 1; e.wreg = 3;
        drive(32'h00C01820, 32'h8, e);
        // add $4,$0,$6 while WB targets $0
        cyc(); regwriteW = 1; write_regW = 0; result_to_writeW = 32'h55;
        e = base(3, 32'h00062020, 32'hC, 0, 6); e.regwrite = 1; e.wreg = 4;
        drive(32'h00062020, 32'hC, e);
        // sub $5,$0,$0
        cyc(); e = base(4, 32'h00002822, 32'h10, 0, 0); e.regwrite = 1; e.wreg = 5; e.aluc = 4'h1;
        drive(32'h00002822, 32'h10, e);
        // lw $2,4($0)
        cyc(); e = base(5, 32'h8C020004, 32'h14, 0, 0);
        e.regwrite = 1; e.mem2reg = 1; e.alusrc = 1; e.wreg = 2; e.loads = 5'b00001;
        drive(32'h8C020004, 32'h14, e);
        // add $7,$2,$0 directly behind the load: stall
        cyc(); e = '0; e.id = 6;
        drive(32'h00403820, 32'h18, e);
        chk("load_use set", {31'd0, load_use}, 32'd1);
        // retry, load data arriving via WB bypass
        cyc(); regwriteW = 1; write_regW = 2; result_to_writeW = 32'h77;
        e = base(7, 32'h00403820, 32'h18, 32'h77, 0); e.regwrite = 1; e.wreg = 7;
        drive(32'h00403820, 32'h18, e);
        chk("load_use clear", {31'd0, load_use}, 32'd0);
        // j 0x100
        cyc(); e = base(8, 32'h08000100, 32'h4, 0, 0);
        drive(32'h08000100, 32'h4, e);
        chk("j jumpI", {31'd0, jumpI}, 32'd1);
        chk("j pc_jumpI", pc_jumpI, 32'h00000400);
        // jr $6
        cyc(); e = base(9, 32'h00C00008, 32'h30, 6, 0);
        drive(32'h00C00008, 32'h30, e);
        chk("jr jumpI", {31'd0, jumpI}, 32'd1);
        chk("jr pc_jumpI", pc_jumpI, 32'd6);
        // mfhi $8 with EXE forwarding HI/LO
        cyc(); mdcsE2D = 1; mdhidataE2D = 32'hA; mdlodataE2D = 32'hB;
        e = base(10, 32'h00004010, 32'h34, 0, 0); e.hi = 32'hA; e.lo = 32'hB;
        e.regwrite = 1; e.wreg = 8; e.mfhi = 1;
        drive(32'h00004010, 32'h34, e);
        chk("mfhi MDPause idle", {31'd0, MDPause}, 32'd0);
        // mflo $9 with WB writing HI/LO
        cyc(); mdcsW = 1; mdhidataW = 32'hC; mdlodataW = 32'hF;
        e = base(11, 32'h00004812, 32'h38, 0, 0); e.hi = 32'hC; e.lo = 32'hF;
        e.regwrite = 1; e.wreg = 9; e.mflo = 1;
        drive(32'h00004812, 32'h38, e);
        mHi = 32'hC; mLo = 32'hF;
        // mfhi $8 from stored HI
        cyc(); e = base(12, 32'h00004010, 32'h3C, 0, 0); e.regwrite = 1; e.wreg = 8; e.mfhi = 1;
        drive(32'h00004010, 32'h3C, e);
        // mflo while divider busy
        cyc(); divbusyE = 1; e = '0; e.id = 13;
        drive(32'h00004812, 32'h40, e);
        chk("div busy MDPause", {31'd0, MDPause}, 32'd1);
        // mult while EXE holds a mult/div
        cyc(); keepmdE = 1; e = '0; e.id = 14;
        drive(32'h00220018, 32'h44, e);
        chk("keepmd MDPause", {31'd0, MDPause}, 32'd1);
        // mult $1,$2 ; multiplier busy but done
        cyc(); multbusyE = 1; multoverE = 1;
        e = base(15, 32'h00220018, 32'h44, 0, 32'h77); e.md = 1; e.aluMd = 2'b00;
        drive(32'h00220018, 32'h44, e);
        chk("mult over MDPause", {31'd0, MDPause}, 32'd0);
        // divu $6,$2
        cyc(); e = base(16, 32'h00C2001B, 32'h48, 6, 32'h77); e.md = 1; e.aluMd = 2'b11;
        drive(32'h00C2001B, 32'h48, e);
        // sw $6,8($2) / sb $6,8($2)
        cyc(); e = base(17, 32'hAC460008, 32'h4C, 32'h77, 6); e.alusrc = 1; e.memw = 4'b1111;
        drive(32'hAC460008, 32'h4C, e);
        cyc(); e = base(18, 32'hA0460008, 32'h50, 32'h77, 6); e.alusrc = 1; e.memw = 4'b0001;
        drive(32'hA0460008, 32'h50, e);
        // andi zero-extends, addi sign-extends
        cyc(); e = base(19, 32'h30CA8000, 32'h54, 6, 0);
        e.regwrite = 1; e.alusrc = 1; e.aluc = 4'h2; e.wreg = 10; e.imm = 32'h00008000;
        drive(32'h30CA8000, 32'h54, e);
        cyc(); e = base(20, 32'h20CA8000, 32'h58, 6, 0);
        e.regwrite = 1; e.alusrc = 1; e.wreg = 10; e.imm = 32'hFFFF8000;
        drive(32'h20CA8000, 32'h58, e);
        // jal 0x40 with upper PC bits set
        cyc(); e = base(21, 32'h0C000040, 32'h10000008, 0, 0);
        e.regwrite = 1; e.wreg = 31; e.w31 = 1;
        drive(32'h0C000040, 32'h10000008, e);
        chk("jal pc_jumpI", pc_jumpI, 32'h10000100);
        chk("jal jumpI", {31'd0, jumpI}, 32'd1);
        // beq $6,$2,3
        cyc(); e = base(22, 32'h10C20003, 32'h5C, 6, 32'h77);
        e.branch = 1; e.aluc = 4'h1; e.br = 2'b10;
        drive(32'h10C20003, 32'h5C, e);
        chk("beq jumpI", {31'd0, jumpI}, 32'd0);
        // unsupported opcode decodes as NOP
        cyc(); e = base(23, 32'hFC000000, 32'h60, 0, 0);
        drive(32'hFC000000, 32'h60, e);

        // asynchronous reset between edges
        @(posedge clk); #3;
        @(negedge clk); #2;
        clrn = 1;
        #1;
        chk("async rst ctrl", {7'd0, actCtrl}, 32'd0);
        chk("async rst pcplus4E", pcplus4E, 32'd0);
        chk("async rst signImmeE", signImmeE, 32'd0);
        chk("async rst lo2rdataE", lo2rdataE, 32'd0);
        @(negedge clk); clrn = 0;
        mHi = 0; mLo = 0;
        // regfile and HI must be cleared
        cyc(); e = base(24, 32'h00C21820, 32'h4, 0, 0); e.regwrite = 1; e.wreg = 3;
        drive(32'h00C21820, 32'h4, e);
        cyc(); e = base(25, 32'h00004010, 32'h8, 0, 0); e.regwrite = 1; e.wreg = 8; e.mfhi = 1;
        drive(32'h00004010, 32'h8, e);

        @(posedge clk); #3;
        chk("scoreboard drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
